// File: rtl/chunk_pack.sv
// chunk_pack: packs narrow chunks little-endian into a wide word.
// A word closes when full or on in_last; one-cycle output latency.
module chunk_pack #(
    parameter int unsigned width = 32'd16,
    parameter int unsigned chunk = 32'd4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [chunk-1:0]                   in_data,
    input  logic                               in_valid,
    input  logic                               in_last,
    output logic                               in_ready,
    output logic [width-1:0]                   out_data,
    output logic                               out_valid,
    output logic                               out_last,
    output logic [$clog2(width/chunk):0]       out_count,
    input  logic                               out_ready
);

    localparam int unsigned N  = width / chunk;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = IW + 1;

    logic [IW-1:0]    r_cnt;
    logic [width-1:0] r_acc;
    logic [width-1:0] r_out_data;
    logic [CW-1:0]    r_out_count;
    logic             r_out_valid;
    logic             r_out_last;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_close;
    logic             w_consume;
    logic [width-1:0] w_slot;

    logic [IW-1:0]    w_cnt_nxt;
    logic [width-1:0] w_acc_nxt;
    logic [width-1:0] w_od_nxt;
    logic [CW-1:0]    w_oc_nxt;
    logic             w_ov_nxt;
    logic             w_ol_nxt;

    assign w_in_ready = rst_n && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_close    = w_accept && (in_last || (r_cnt == IW'(N - 1)));
    assign w_consume  = r_out_valid && out_ready;

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

    // Accumulator with the incoming chunk dropped into slot r_cnt.
    always_comb begin
        w_slot = r_acc;
        for (int k = 0; k < int'(N); k++) begin
            if (r_cnt == IW'(k)) begin
                w_slot[k*chunk +: chunk] = in_data;
            end
        end
    end

    // Next-state: fill, close into the output register, or drain it.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_acc_nxt = r_acc;
        w_od_nxt  = r_out_data;
        w_oc_nxt  = r_out_count;
        w_ol_nxt  = r_out_last;
        w_ov_nxt  = r_out_valid;
        if (w_close) begin
            w_od_nxt  = w_slot;
            w_oc_nxt  = CW'(r_cnt) + CW'(1);
            w_ol_nxt  = in_last;
            w_ov_nxt  = 1'b1;
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
        end else begin
            if (w_accept) begin
                w_acc_nxt = w_slot;
                w_cnt_nxt = r_cnt + IW'(1);
            end
            if (w_consume) begin
                w_ov_nxt = 1'b0;
            end
        end
    end

    // State register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_out_data  <= w_od_nxt;
            r_out_count <= w_oc_nxt;
            r_out_valid <= w_ov_nxt;
            r_out_last  <= w_ol_nxt;
        end
    end

endmodule

// File: tb/tb_chunk_pack.sv
// tb_chunk_pack: directed vector table plus randomized traffic
// checked against a queue-based packing model (width=16, chunk=4).
module tb_chunk_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [2:0]  out_count;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;

    chunk_pack #(.width(16), .chunk(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_count (out_count),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [3:0]  d;
        logic        l;
        logic        o;
        logic        ir;
        logic        ov;
        logic [15:0] od;
        logic [2:0]  oc;
        logic        ol;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [3:0] d,
                       input logic l, input logic o, input logic ir,
                       input logic ov, input logic [15:0] od,
                       input logic [2:0] oc, input logic ol);
        vec_t e;
        e.rst_n = r; e.v = v; e.d = d; e.l = l; e.o = o;
        e.ir = ir; e.ov = ov; e.od = od; e.oc = oc; e.ol = ol;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] d,
                         input logic l, input logic o);
        @(negedge clk);
        rst_n = r; in_valid = v; in_data = d; in_last = l; out_ready = o;
        #1;
    endtask

    // Packing model state: chunks of the open word and the output register.
    int unsigned part[$];
    logic        m_ov;
    logic [15:0] m_od;
    logic [2:0]  m_oc;
    logic        m_ol;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b0;

        // reset, then 1,2,3,4 -> 0x4321 for one cycle
        add(0,0,4'h0,0,1, 0, 0,16'h0000,0,0);
        add(1,1,4'h1,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h2,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h3,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h4,0,1, 1, 1,16'h4321,4,0);
        add(1,0,4'h0,0,1, 1, 0,16'h0000,0,0);
        // A, B+last -> 0x00BA; next word starts in slot 0
        add(1,1,4'hA,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'hB,1,1, 1, 1,16'h00BA,2,1);
        add(1,1,4'hC,1,1, 1, 1,16'h000C,1,1);
        // stalled output holds; 5 waits, then accepted with the drain
        add(1,1,4'h5,0,0, 0, 1,16'h000C,1,1);
        add(1,1,4'h5,0,0, 0, 1,16'h000C,1,1);
        add(1,1,4'h5,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h6,1,1, 1, 1,16'h0065,2,1);
        // stream 0..7
        add(1,1,4'h0,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h1,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h2,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h3,0,1, 1, 1,16'h3210,4,0);
        add(1,1,4'h4,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h5,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h6,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h7,0,1, 1, 1,16'h7654,4,0);
        // partial word discarded by reset
        add(1,1,4'h1,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h2,0,1, 1, 0,16'h0000,0,0);
        add(0,1,4'h3,0,1, 0, 0,16'h0000,0,0);
        add(1,1,4'h9,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h8,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h7,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h6,0,1, 1, 1,16'h6789,4,0);
        // pending word dropped by reset; first chunk F+last
        add(0,0,4'h0,0,0, 0, 0,16'h0000,0,0);
        add(1,1,4'hF,1,1, 1, 1,16'h000F,1,1);
        add(1,0,4'h0,0,1, 1, 0,16'h0000,0,0);
        // last on the N-th chunk -> full word with out_last
        add(1,1,4'h1,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h2,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h3,0,1, 1, 0,16'h0000,0,0);
        add(1,1,4'h4,1,1, 1, 1,16'h4321,4,1);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].o);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready),
                32'(tbl[i].ir));
            @(posedge clk); #1;
            if (tbl[i].ov || !tbl[i].rst_n)
                chk($sformatf("vec%0d out", i),
                    32'({out_valid, out_data, out_count, out_last}),
                    32'({tbl[i].ov, tbl[i].od, tbl[i].oc, tbl[i].ol}));
            else
                chk($sformatf("vec%0d out_valid", i), 32'(out_valid),
                    32'(tbl[i].ov));
        end

        // randomized traffic against the packing model
        drive(0, 0, 4'h0, 0, 0);
        @(posedge clk); #1;
        part.delete();
        m_ov = 0; m_od = '0; m_oc = '0; m_ol = 0;
        for (int c = 0; c < 600; c++) begin
            logic r, v, l, o, exp_ir, take;
            logic [3:0] d;
            logic [15:0] w;
            r = ($urandom_range(0, 49) != 0);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 4) == 0);
            o = ($urandom_range(0, 9) < 7);
            d = 4'($urandom_range(0, 15));
            drive(r, v, d, l, o);
            exp_ir = r && (!m_ov || o);
            chk($sformatf("rnd%0d in_ready", c), 32'(in_ready),
                32'(exp_ir));
            take = v && exp_ir;
            if (!r) begin
                part.delete();
                m_ov = 0; m_od = '0; m_oc = '0; m_ol = 0;
            end else begin
                if (m_ov && o) m_ov = 0;
                if (take) begin
                    part.push_back(int'(d));
                    if (l || part.size() == 4) begin
                        w = '0;
                        foreach (part[k]) w = w | 16'(part[k] << (4 * k));
                        m_od = w;
                        m_oc = 3'(part.size());
                        m_ol = l;
                        m_ov = 1;
                        part.delete();
                    end
                end
            end
            @(posedge clk); #1;
            if (m_ov || !r)
                chk($sformatf("rnd%0d out", c),
                    32'({out_valid, out_data, out_count, out_last}),
                    32'({m_ov, m_od, m_oc, m_ol}));
            else
                chk($sformatf("rnd%0d out_valid", c), 32'(out_valid),
                    32'(m_ov));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chunk_pack.md
CHUNK_PACK -- requirements
Module: chunk_pack

Interface
REQ-001 The module SHALL have parameter `width`, default 32'd16: assembled word width in bits.
REQ-002 The module SHALL have parameter `chunk`, default 32'd4: input chunk width in bits.
REQ-003 `width` SHALL be an integer multiple of `chunk`, with N = width/chunk >= 2; other values are unsupported.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port in_data, input, `chunk` bits: incoming chunk.
REQ-007 The module SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The module SHALL have port in_last, input, 1 bit: this chunk closes the current word early.
REQ-009 The module SHALL have port in_ready, output, 1 bit: the module accepts a chunk this cycle.
REQ-010 The module SHALL have port out_data, output, `width` bits: assembled word, which feeds the downstream slice/concat stage.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 The module SHALL have port out_last, output, 1 bit: the word was closed by in_last.
REQ-013 The module SHALL have port out_count, output, $clog2(N)+1 bits: number of valid chunks in out_data (1..N).
REQ-014 The module SHALL have port out_ready, input, 1 bit: downstream accepts the word.

Function
REQ-015 A chunk SHALL be accepted in a cycle exactly when in_valid && in_ready is true at the rising edge (in); a word SHALL be consumed exactly when out_valid && out_ready is true (out).
REQ-016 in_ready SHALL equal rst_n && (!out_valid || out_ready), so it never depends on in_valid, in_data or in_last.
REQ-017 Internal state SHALL be a fill counter cnt (0..N-1) and an accumulator acc (`width` bits); cnt==0 is state EMPTY and cnt>0 is state FILLING.
REQ-018 Packing order SHALL be first-accepted chunk into bits [chunk-1:0], the k-th chunk into bits [(k+1)*chunk-1 : k*chunk] (little-endian, same as the concat in0-low convention).
REQ-019 On an accepted chunk with cnt<N-1 and in_last==0, the chunk SHALL be written to acc slot cnt and cnt SHALL increment; no output change results.
REQ-020 On an accepted chunk with cnt==N-1 or in_last==1, the word SHALL close:
  - out_data <= acc with the chunk placed in slot cnt, and all higher slots zero;
  - out_count <= cnt+1;
  - out_last <= in_last;
  - out_valid <= 1;
  - acc <= 0 and cnt <= 0.
REQ-021 Latency SHALL be one cycle: out_valid asserts in the cycle after the edge that accepted a word's closing chunk.
REQ-022 If a word is consumed and no new word closes on the same edge, out_valid SHALL deassert; if both happen on the same edge, the new word SHALL replace it with out_valid remaining 1.
REQ-023 out_data, out_count and out_last SHALL hold stable while out_valid==1 && out_ready==0.
REQ-024 Throughput SHALL be one chunk per cycle with no bubbles while out_ready is held at 1.
REQ-025 in_last on a chunk arriving in EMPTY SHALL produce a one-chunk word with out_count=1.
REQ-026 in_last on a chunk arriving at cnt==N-1 SHALL produce a full word with out_last=1.
REQ-027 in_data and in_last SHALL be ignored while in_valid==0 or in_ready==0.

Reset
REQ-028 While rst_n==0 at a rising edge, the module SHALL clear out_valid, out_data, out_last, out_count, cnt and acc to 0.
REQ-029 in_ready SHALL be 0 while rst_n==0.
REQ-030 A partially filled word SHALL be discarded by reset, and a pending output word SHALL be dropped without being consumed.
REQ-031 The first chunk accepted after reset SHALL land in slot 0.

Verification
(All scenarios use width=16, chunk=4.)
REQ-032 The bench SHALL cover: reset, then chunks 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=1 -> out_data=0x4321, out_count=4, out_last=0, out_valid high for exactly one cycle, one cycle after the 4th accept.
REQ-033 The bench SHALL cover: chunks 0xA, then 0xB with in_last=1 -> out_data=0x00BA, out_count=2, out_last=1; next word starts at slot 0.
REQ-034 The bench SHALL cover: a word pending with out_ready=0 while 0x5 is held valid -> in_ready=0, 0x5 not accepted, out_data stable; raise out_ready -> word consumed and 0x5 accepted on the same edge.
REQ-035 The bench SHALL cover: chunks 0x0..0x7 streamed with out_ready=1 -> words 0x3210 then 0x7654, in_ready constantly 1.
REQ-036 The bench SHALL cover: accept 0x1,0x2, assert rst_n=0 for one cycle, then send 0x9,0x8,0x7,0x6 -> single word 0x6789 with no residue of 0x1/0x2.
REQ-037 The bench SHALL cover: first chunk 0xF with in_last=1 -> out_data=0x000F, out_count=1, out_last=1.
